// File: rtl/crossing_barrier_driver.sv
// Purpose : railway crossing actuator stage; sequences warning, barrier travel, lamp flashing, bell, latched fault.
// Latency : all outputs registered, one cycle from the sampling edge (decoded from the next state).
// Backpressure: none; requests and limit switches are sampled every cycle, a fault holds until reset.
// Ports   : clk/reset (sync, active-high); enable, gate, red_light requests; limit_up/limit_down switches;
//           lamp_l/lamp_r, bell, motor_dn/motor_up drives; barrier_down status; fault latch.
module crossing_barrier_driver #(
    parameter int WARN_CYC   = 8,
    parameter int FLASH_CYC  = 4,
    parameter int TRAVEL_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic gate,
    input  logic red_light,
    input  logic limit_up,
    input  logic limit_down,
    output logic lamp_l,
    output logic lamp_r,
    output logic bell,
    output logic motor_dn,
    output logic motor_up,
    output logic barrier_down,
    output logic fault
);

    localparam int PH_TOP = (WARN_CYC > TRAVEL_MAX) ? WARN_CYC : TRAVEL_MAX;
    localparam int PW     = $clog2(PH_TOP + 1);
    localparam int FW     = $clog2(FLASH_CYC + 1);

    localparam logic [PW-1:0] WARN_LAST   = PW'(WARN_CYC - 1);
    localparam logic [PW-1:0] TRAVEL_LAST = PW'(TRAVEL_MAX - 1);
    localparam logic [FW-1:0] FLASH_LAST  = FW'(FLASH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARN,
        S_LOWERING,
        S_DOWN,
        S_RAISING,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   phase_cnt;
    logic [PW-1:0]   phase_nxt;
    logic [FW-1:0]   flash_cnt;
    logic            both_limits;
    logic            warn_done;
    logic            travel_done;
    logic            lamps_act_nxt;

    assign both_limits = limit_up & limit_down;
    // Counter is cleared on state entry, so it reads N-1 on the Nth edge after entry.
    assign warn_done   = (phase_cnt == WARN_LAST);
    assign travel_done = (phase_cnt == TRAVEL_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (enable && (gate || red_light)) state_nxt = S_WARN;
            end
            S_WARN: begin
                if (warn_done) begin
                    if (gate)           state_nxt = S_LOWERING;
                    else if (red_light) state_nxt = S_WARN;
                    else                state_nxt = S_IDLE;
                end else if (!gate && !red_light) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOWERING: begin
                if (limit_down)       state_nxt = S_DOWN;
                else if (!gate)       state_nxt = S_RAISING;
                else if (travel_done) state_nxt = S_FAULT;
            end
            S_DOWN: begin
                if (!gate) state_nxt = S_RAISING;
            end
            S_RAISING: begin
                if (limit_up)         state_nxt = S_IDLE;
                else if (gate)        state_nxt = S_LOWERING;
                else if (travel_done) state_nxt = S_FAULT;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
        // Mechanically impossible switch combination overrides everything.
        if (both_limits) state_nxt = S_FAULT;
    end

    always_comb begin
        phase_nxt = '0;
        if (state_nxt == state) begin
            case (state)
                // Saturate in WARN so a late gate request lowers on the very next edge.
                S_WARN:                phase_nxt = warn_done ? phase_cnt : phase_cnt + 1'b1;
                S_LOWERING, S_RAISING: phase_nxt = phase_cnt + 1'b1;
                default:               phase_nxt = '0;
            endcase
        end
    end

    // Lamps also stay lit in IDLE while the controller still asks for red,
    // so the flash rhythm is not restarted across a raise-then-rewarn.
    assign lamps_act_nxt = (state_nxt != S_IDLE) || (enable && red_light);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            flash_cnt    <= '0;
            lamp_l       <= 1'b0;
            lamp_r       <= 1'b0;
            bell         <= 1'b0;
            motor_dn     <= 1'b0;
            motor_up     <= 1'b0;
            barrier_down <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase_cnt    <= phase_nxt;
            bell         <= (state_nxt == S_WARN) || (state_nxt == S_LOWERING) ||
                            (state_nxt == S_RAISING) || (state_nxt == S_FAULT);
            motor_dn     <= (state_nxt == S_LOWERING);
            motor_up     <= (state_nxt == S_RAISING);
            barrier_down <= (state_nxt == S_DOWN);
            fault        <= (state_nxt == S_FAULT);

            if (!lamps_act_nxt) begin
                flash_cnt <= '0;
                lamp_l    <= 1'b0;
                lamp_r    <= 1'b0;
            end else if (!(lamp_l || lamp_r)) begin
                // Activation edge: left lamp always lights first.
                flash_cnt <= '0;
                lamp_l    <= 1'b1;
                lamp_r    <= 1'b0;
            end else if (flash_cnt == FLASH_LAST) begin
                flash_cnt <= '0;
                lamp_l    <= ~lamp_l;
                lamp_r    <= ~lamp_r;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crossing_barrier_driver.sv
// Purpose : self-checking bench for crossing_barrier_driver against a timestamp-based reference model.
// Latency : expects outputs one cycle after the sampling edge; sampled 1 time unit after each rising edge.
// Backpressure: n/a; directed scenarios followed by randomized requests, limits and resets.
module tb_crossing_barrier_driver;

    localparam int W = 8;
    localparam int F = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset, enable, gate, red_light, limit_up, limit_down;
    logic lamp_l, lamp_r, bell, motor_dn, motor_up, barrier_down, fault;

    crossing_barrier_driver #(
        .WARN_CYC  (W),
        .FLASH_CYC (F),
        .TRAVEL_MAX(T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .gate        (gate),
        .red_light   (red_light),
        .limit_up    (limit_up),
        .limit_down  (limit_down),
        .lamp_l      (lamp_l),
        .lamp_r      (lamp_r),
        .bell        (bell),
        .motor_dn    (motor_dn),
        .motor_up    (motor_up),
        .barrier_down(barrier_down),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_WARN, M_LOWER, M_DOWN, M_RAISE, M_FAULT} mode_t;

    mode_t m_mode     = M_IDLE;
    int    t_now      = 0;
    int    t_entry    = 0;
    int    lamp_start = -1;
    int    checks     = 0;
    int    errors     = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b (t=%0d)", tag, obs, exp, t_now);
        end
    endtask

    // Reference: time is an edge count; dwell and timeout are elapsed time since mode entry,
    // lamp phase is elapsed time since lamp activation divided by the half-period.
    task automatic model_step();
        mode_t nm;
        int    el;
        t_now++;
        if (reset) begin
            m_mode     = M_IDLE;
            t_entry    = t_now;
            lamp_start = -1;
        end else begin
            el = t_now - t_entry;
            nm = m_mode;
            if (limit_up && limit_down) nm = M_FAULT;
            else begin
                case (m_mode)
                    M_IDLE:  if (enable && (gate || red_light)) nm = M_WARN;
                    M_WARN:  if (el >= W) nm = gate ? M_LOWER : (red_light ? M_WARN : M_IDLE);
                             else if (!gate && !red_light) nm = M_IDLE;
                    M_LOWER: if (limit_down) nm = M_DOWN;
                             else if (!gate) nm = M_RAISE;
                             else if (el >= T) nm = M_FAULT;
                    M_DOWN:  if (!gate) nm = M_RAISE;
                    M_RAISE: if (limit_up) nm = M_IDLE;
                             else if (gate) nm = M_LOWER;
                             else if (el >= T) nm = M_FAULT;
                    default: nm = M_FAULT;
                endcase
            end
            if (nm != m_mode) begin
                m_mode  = nm;
                t_entry = t_now;
            end
            if (m_mode != M_IDLE || (enable && red_light)) begin
                if (lamp_start < 0) lamp_start = t_now;
            end else begin
                lamp_start = -1;
            end
        end
    endtask

    task automatic tick();
        logic e_bell, e_l, e_r, even;
        @(posedge clk);
        model_step();
        #1;
        e_bell = (m_mode == M_WARN) || (m_mode == M_LOWER) || (m_mode == M_RAISE) || (m_mode == M_FAULT);
        even   = (lamp_start >= 0) && ((((t_now - lamp_start) / F) % 2) == 0);
        e_l    = (lamp_start >= 0) && even;
        e_r    = (lamp_start >= 0) && !even;
        check("bell",         bell,         e_bell);
        check("motor_dn",     motor_dn,     m_mode == M_LOWER);
        check("motor_up",     motor_up,     m_mode == M_RAISE);
        check("barrier_down", barrier_down, m_mode == M_DOWN);
        check("fault",        fault,        m_mode == M_FAULT);
        check("lamp_l",       lamp_l,       e_l);
        check("lamp_r",       lamp_r,       e_r);
        check("motor_overlap", motor_dn & motor_up, 1'b0);
        check("lamp_overlap",  lamp_l & lamp_r,     1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; gate = 1'b0; red_light = 1'b0;
        limit_up = 1'b0; limit_down = 1'b0;
        ticks(2);
        check("reset_fault", fault, 1'b0);
        check("reset_bell",  bell,  1'b0);
        reset = 1'b0;

        // Warning then lowering onto limit_down.
        enable = 1'b1; gate = 1'b1; red_light = 1'b1;
        tick();
        check("bell_rise", bell, 1'b1);
        check("lamp_l_first", lamp_l, 1'b1);
        ticks(W - 1);
        check("dn_before_dwell", motor_dn, 1'b0);
        tick();
        check("dn_after_dwell", motor_dn, 1'b1);
        ticks(4);
        limit_down = 1'b1;
        tick();
        check("down_status", barrier_down, 1'b1);
        check("down_motor",  motor_dn,     1'b0);
        check("down_bell",   bell,         1'b0);

        // Raise back to IDLE.
        gate = 1'b0;
        tick();
        check("raise_motor", motor_up, 1'b1);
        limit_down = 1'b0;
        ticks(5);
        limit_up = 1'b1; red_light = 1'b0;
        tick();
        check("idle_motor_up", motor_up, 1'b0);
        check("idle_lamp_l",   lamp_l,   1'b0);
        check("idle_bell",     bell,     1'b0);
        limit_up = 1'b0;
        tick();

        // Lamp rhythm in WARN held by red_light only.
        red_light = 1'b1;
        for (int i = 0; i < F; i++) begin
            tick();
            check("flash_left", lamp_l, 1'b1);
        end
        for (int i = 0; i < F; i++) begin
            tick();
            check("flash_right", lamp_r, 1'b1);
        end
        ticks(3);

        // Saturated WARN lowers immediately on gate, then times out.
        gate = 1'b1;
        tick();
        check("sat_warn_lower", motor_dn, 1'b1);
        ticks(T - 1);
        check("pre_timeout", fault, 1'b0);
        tick();
        check("timeout_fault", fault, 1'b1);
        check("timeout_motor", motor_dn, 1'b0);
        gate = 1'b0; red_light = 1'b0;
        ticks(3);
        gate = 1'b1; red_light = 1'b1;
        ticks(2);
        check("fault_held", fault, 1'b1);
        reset = 1'b1;
        tick();
        check("fault_cleared", fault, 1'b0);
        reset = 1'b0;

        // Reversals in both directions, then both-limits fault from DOWN.
        tick();
        ticks(W);
        ticks(3);
        gate = 1'b0;
        tick();
        check("rev_up", motor_up, 1'b1);
        ticks(3);
        gate = 1'b1;
        tick();
        check("rev_dn", motor_dn, 1'b1);
        limit_down = 1'b1;
        tick();
        limit_up = 1'b1;
        tick();
        check("both_limits", fault, 1'b1);
        limit_up = 1'b0; limit_down = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Disabled IDLE ignores requests.
        enable = 1'b0; gate = 1'b1; red_light = 1'b0;
        ticks(5);
        check("disabled_bell", bell, 1'b0);
        check("disabled_lamp", lamp_l, 1'b0);

        // Randomized operation.
        enable = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(63) == 0);
            if ($urandom_range(11) == 0) gate = ~gate;
            if ($urandom_range(9) == 0)  red_light = ~red_light;
            if ($urandom_range(19) == 0) enable = ~enable;
            limit_down = ($urandom_range(9) == 0);
            limit_up   = ($urandom_range(9) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
